block_merger: RTL

BLOCK_MERGER -- requirements
Module: block_merger

---
 rtl/mure_pkg.sv | 25 ++
 rtl/iretire_counter.sv | 48 ++++
 rtl/block_merger.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mure_pkg.sv
// Shared widths and type codes for the trace block merger.
package mure_pkg;

  localparam int ITYPE_LEN   = 3;
  localparam int XLEN        = 64;
  localparam int IRETIRE_LEN = 16;

  // Per-instruction type codes; UNDEF is folded into STD by the merger.
  typedef enum logic [ITYPE_LEN-1:0] {
    STD      = 3'd0,
    EXC      = 3'd1,
    INTR     = 3'd2,
    ERET     = 3'd3,
    NTBR     = 3'd4,
    TBR      = 3'd5,
    UPDISCON = 3'd6,
    UNDEF    = 3'd7
  } itype_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } merge_state_e;

endpackage

// File: rtl/iretire_counter.sv
// Open-block accumulator: start address, retired-halfword count, last size.
module iretire_counter
  import mure_pkg::*;
#(
  parameter int XLEN        = mure_pkg::XLEN,
  parameter int IRETIRE_LEN = mure_pkg::IRETIRE_LEN
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   open_i,      // a block is currently open
  input  logic                   acc_i,       // fold this instruction into the block
  input  logic                   clr_i,       // block closed, forget it
  input  logic [XLEN-1:0]        iaddr_i,
  input  logic                   ilastsize_i,
  output logic [XLEN-1:0]        start_o,
  output logic [IRETIRE_LEN-1:0] count_o,
  output logic                   last_o,
  output logic [IRETIRE_LEN:0]   sum_o        // count including this instruction, one bit wider
);

  logic [1:0]             size;
  logic [IRETIRE_LEN-1:0] base;

  // Halfwords of the presented instruction added to whatever is open.
  always_comb begin
    size  = ilastsize_i ? 2'd2 : 2'd1;
    base  = open_i ? count_o : '0;
    sum_o = {1'b0, base} + {{(IRETIRE_LEN-1){1'b0}}, size};
  end

  // Accumulation state; a fresh block latches its start address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      start_o <= '0;
      count_o <= '0;
      last_o  <= 1'b0;
    end else if (clr_i) begin
      start_o <= '0;
      count_o <= '0;
      last_o  <= 1'b0;
    end else if (acc_i) begin
      if (!open_i) start_o <= iaddr_i;
      count_o <= sum_o[IRETIRE_LEN-1:0];
      last_o  <= ilastsize_i;
    end
  end

endmodule

// File: rtl/block_merger.sv
// Merges retired instructions into address blocks closed by control-flow events.
module block_merger
  import mure_pkg::*;
#(
  parameter int ITYPE_LEN   = mure_pkg::ITYPE_LEN,
  parameter int XLEN        = mure_pkg::XLEN,
  parameter int IRETIRE_LEN = mure_pkg::IRETIRE_LEN
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [ITYPE_LEN-1:0]   itype_i,
  input  logic [XLEN-1:0]        iaddr_i,
  input  logic                   ilastsize_i,
  output logic                   block_valid_o,
  input  logic                   block_ready_i,
  output logic [XLEN-1:0]        iaddr_o,
  output logic [IRETIRE_LEN-1:0] iretire_o,
  output logic [ITYPE_LEN-1:0]   itype_o,
  output logic                   ilastsize_o
);

  // Close before the count can no longer absorb a 32-bit instruction.
  localparam logic [IRETIRE_LEN:0] SAT = {1'b0, {(IRETIRE_LEN-1){1'b1}}, 1'b0};

  merge_state_e state_q, state_d;

  logic                   accept, is_incl, is_excl, open;
  logic                   acc, clr, close;
  logic [XLEN-1:0]        c_start;
  logic [IRETIRE_LEN-1:0] c_count;
  logic                   c_last;
  logic [IRETIRE_LEN:0]   c_sum;

  logic [XLEN-1:0]        blk_addr;
  logic [IRETIRE_LEN-1:0] blk_ret;
  logic [ITYPE_LEN-1:0]   blk_type;
  logic                   blk_last;

  assign ready_o = !block_valid_o || block_ready_i;
  assign accept  = valid_i && ready_o;
  assign open    = (state_q == ACCUM);
  assign is_excl = (itype_i == ITYPE_LEN'(EXC)) || (itype_i == ITYPE_LEN'(INTR));
  assign is_incl = (itype_i == ITYPE_LEN'(ERET)) || (itype_i == ITYPE_LEN'(NTBR)) ||
                   (itype_i == ITYPE_LEN'(TBR))  || (itype_i == ITYPE_LEN'(UPDISCON));

  iretire_counter #(
    .XLEN        (XLEN),
    .IRETIRE_LEN (IRETIRE_LEN)
  ) u_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .open_i      (open),
    .acc_i       (acc),
    .clr_i       (clr),
    .iaddr_i     (iaddr_i),
    .ilastsize_i (ilastsize_i),
    .start_o     (c_start),
    .count_o     (c_count),
    .last_o      (c_last),
    .sum_o       (c_sum)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, accumulator controls and the closing block's fields.
  always_comb begin
    state_d  = state_q;
    acc      = 1'b0;
    clr      = 1'b0;
    close    = 1'b0;
    blk_addr = open ? c_start : iaddr_i;
    blk_ret  = c_sum[IRETIRE_LEN-1:0];
    blk_type = itype_i;
    blk_last = ilastsize_i;
    if (accept) begin
      if (is_incl) begin
        close   = 1'b1;
        clr     = 1'b1;
        state_d = IDLE;
      end else if (is_excl) begin
        close   = 1'b1;
        clr     = 1'b1;
        state_d = IDLE;
        blk_ret  = open ? c_count : '0;
        blk_last = open ? c_last  : 1'b0;
      end else if (c_sum >= SAT) begin
        // STD or undefined type that fills the counter
        close    = 1'b1;
        clr      = 1'b1;
        state_d  = IDLE;
        blk_type = '0;
      end else begin
        acc     = 1'b1;
        state_d = ACCUM;
      end
    end
  end

  // One-entry output register; a drain and a new close in one cycle reloads it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      block_valid_o <= 1'b0;
      iaddr_o       <= '0;
      iretire_o     <= '0;
      itype_o       <= '0;
      ilastsize_o   <= 1'b0;
    end else if (close) begin
      block_valid_o <= 1'b1;
      iaddr_o       <= blk_addr;
      iretire_o     <= blk_ret;
      itype_o       <= blk_type;
      ilastsize_o   <= blk_last;
    end else if (block_ready_i) begin
      block_valid_o <= 1'b0;
    end
  end

endmodule
